// File: rtl/fb_pkg.sv
// Shared types for the framebuffer writer: FSM encoding, bus widths and the queued pixel entry.
package fb_pkg;
  localparam int ADDR_W  = 16;
  localparam int COLOR_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0]         py;
    logic [7:0]         px;
    logic [COLOR_W-1:0] color;
  } pix_t;

  localparam int PIX_W = $bits(pix_t);
endpackage

// File: rtl/fb_writer_if.sv
// Framebuffer memory write port; master issues req/addr/data, slave answers with ack.
interface fb_writer_if;
  import fb_pkg::*;

  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_wdata;
  logic               mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack);
endinterface

// File: rtl/pixel_fifo.sv
// Generic FIFO with a registered head word; push is ignored when full unless a pop frees a slot.
// Latency: a word pushed into an empty FIFO is on head_o one cycle later; no backpressure to pusher.
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_next;
  logic [AW:0]      cnt_q, cnt_d, cnt_left;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == FULL_CNT);
  assign do_pop   = pop_i && !empty_o;
  assign do_push  = push_i && (!full_o || do_pop);
  assign rd_next  = rd_ptr_q + AW'(do_pop);
  assign cnt_left = cnt_q - (AW+1)'(do_pop);
  assign cnt_d    = cnt_left + (AW+1)'(do_push);
  // When the slot becoming head is the one being written now, bypass the array.
  assign head_d   = (do_push && cnt_left == '0) ? push_dat_i : mem_q[rd_next];
  assign head_o   = head_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_next;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end
endmodule

// File: rtl/fb_writer.sv
// Queues drawn pixels and writes them (or a full-screen clear) into framebuffer memory.
// Latency: idle pixel reaches mem_req 2 cycles after pixel_valid; pixels dropped (overflow) when FIFO full.
module fb_writer import fb_pkg::*; #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pixel_valid,
  input  logic [7:0]         px,
  input  logic [7:0]         py,
  input  logic [COLOR_W-1:0] pixel_color,
  input  logic               done,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  fb_writer_if.master        mem,
  output logic               busy,
  output logic               overflow,
  output logic               frame_done,
  output logic [15:0]        pixel_count
);
  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;
  logic               done_q, frame_pend_q, overflow_q;
  logic [15:0]        pix_cnt_q;
  logic               clr_start, fifo_full, fifo_empty, fifo_pop, px_drop;
  logic               req_c, fdone_c;
  logic [ADDR_W-1:0]  addr_c;
  logic [COLOR_W-1:0] wdata_c;
  pix_t               push_ent, head;

  assign push_ent = '{py: py, px: px, color: pixel_color};

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PIX_W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (pixel_valid),
    .push_dat_i (push_ent),
    .pop_i      (fifo_pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head)
  );

  assign fifo_pop = (state_q == ST_WRITE) && !fifo_empty && mem.mem_ack;
  assign px_drop  = pixel_valid && fifo_full && !fifo_pop;

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    clr_start   = 1'b0;
    req_c       = 1'b0;
    addr_c      = '0;
    wdata_c     = '0;
    fdone_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req && fifo_empty) begin
          state_d     = ST_CLEAR;
          clr_addr_d  = '0;
          clr_color_d = clear_color;
          clr_start   = 1'b1;
        end else if (!fifo_empty) begin
          state_d = ST_WRITE;
        end else if (frame_pend_q) begin
          state_d = ST_FLUSH;
        end
      end
      ST_WRITE: begin
        if (fifo_empty) begin
          state_d = frame_pend_q ? ST_FLUSH : ST_IDLE;
        end else begin
          req_c   = 1'b1;
          addr_c  = {head.py, head.px};
          wdata_c = head.color;
        end
      end
      ST_CLEAR: begin
        req_c   = 1'b1;
        addr_c  = clr_addr_q;
        wdata_c = clr_color_q;
        if (mem.mem_ack) begin
          // Counter wraps to 0 on the last address, ready for the next clear.
          clr_addr_d = clr_addr_q + 16'd1;
          if (clr_addr_q == 16'hFFFF) state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        fdone_c = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      clr_addr_q   <= '0;
      clr_color_q  <= '0;
      done_q       <= 1'b0;
      frame_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      pix_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      done_q      <= done;
      if (done && !done_q)          frame_pend_q <= 1'b1;
      else if (state_q == ST_FLUSH) frame_pend_q <= 1'b0;
      if (clr_start)    overflow_q <= 1'b0;
      else if (px_drop) overflow_q <= 1'b1;
      if (clr_start)                                   pix_cnt_q <= '0;
      else if (fifo_pop && pix_cnt_q != 16'hFFFF)      pix_cnt_q <= pix_cnt_q + 16'd1;
    end
  end

  assign mem.mem_req   = req_c;
  assign mem.mem_we    = req_c;
  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = wdata_c;
  assign busy          = (state_q != ST_IDLE) || !fifo_empty;
  assign overflow      = overflow_q;
  assign frame_done    = fdone_c;
  assign pixel_count   = pix_cnt_q;
endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer: stimulus queues expected writes, a negedge monitor checks them.
module tb_fb_writer;
  import fb_pkg::*;

  logic        clk, rst_n, pixel_valid, done, clear_req;
  logic [7:0]  px, py;
  logic [23:0] pixel_color, clear_color;
  logic        busy, overflow, frame_done;
  logic [15:0] pixel_count;

  fb_writer_if mif();

  fb_writer #(.FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pixel_valid (pixel_valid),
    .px          (px),
    .py          (py),
    .pixel_color (pixel_color),
    .done        (done),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .mem         (mif),
    .busy        (busy),
    .overflow    (overflow),
    .frame_done  (frame_done),
    .pixel_count (pixel_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [23:0] data;
    bit          bulk;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          checks = 0, failures = 0, writes = 0;
  int          bulk_n = 0, bulk_bad = 0, fd_pulses = 0, fd_at_writes = -1;
  int          w0;
  bit          hold_vld = 1'b0, fd_prev = 1'b0;
  logic [15:0] hold_addr;
  logic [23:0] hold_data;

  // Monitor: checks every accepted write against the queue, request stability, frame_done width.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld = 1'b0;
      fd_prev  = 1'b0;
    end else begin
      if (hold_vld) begin
        checks++;
        if (!(mif.mem_req === 1'b1 && mif.mem_addr === hold_addr && mif.mem_wdata === hold_data)) begin
          failures++;
          $display("FAIL hold_stable req=%b addr=%h data=%h required req=1 addr=%h data=%h",
                   mif.mem_req, mif.mem_addr, mif.mem_wdata, hold_addr, hold_data);
        end
      end
      if (mif.mem_req && mif.mem_ack) begin
        writes++;
        checks++;
        if (mif.mem_we !== 1'b1) begin
          failures++;
          $display("FAIL mem_we actual=%b required=1", mif.mem_we);
        end
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=%h data=%h required=no write", mif.mem_addr, mif.mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if (e.bulk) begin
            bulk_n++;
            if (mif.mem_addr !== e.addr || mif.mem_wdata !== e.data) bulk_bad++;
          end else begin
            checks++;
            if (mif.mem_addr !== e.addr || mif.mem_wdata !== e.data) begin
              failures++;
              $display("FAIL write_%0d addr=%h data=%h required addr=%h data=%h",
                       writes, mif.mem_addr, mif.mem_wdata, e.addr, e.data);
            end
          end
        end
      end
      hold_vld  = mif.mem_req && !mif.mem_ack;
      hold_addr = mif.mem_addr;
      hold_data = mif.mem_wdata;
      if (frame_done) begin
        fd_pulses++;
        fd_at_writes = writes;
        checks++;
        if (fd_prev) begin
          failures++;
          $display("FAIL frame_done_width high for 2 cycles, required 1");
        end
      end
      fd_prev = frame_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send_px(input logic [7:0] x, input logic [7:0] y, input logic [23:0] c,
                         input logic [15:0] exp_addr, input bit expect_write);
    pixel_valid = 1'b1;
    px          = x;
    py          = y;
    pixel_color = c;
    if (expect_write) exp_q.push_back('{addr: exp_addr, data: c, bulk: 1'b0});
    tick();
    pixel_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain remaining=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; pixel_valid = 1'b0; px = '0; py = '0; pixel_color = '0;
    done = 1'b0; clear_req = 1'b0; clear_color = '0; mif.mem_ack = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_mem_req",     32'(mif.mem_req),   32'h0);
    chk("rst_mem_we",      32'(mif.mem_we),    32'h0);
    chk("rst_mem_addr",    32'(mif.mem_addr),  32'h0);
    chk("rst_mem_wdata",   32'(mif.mem_wdata), 32'h0);
    chk("rst_busy",        32'(busy),          32'h0);
    chk("rst_overflow",    32'(overflow),      32'h0);
    chk("rst_frame_done",  32'(frame_done),    32'h0);
    chk("rst_pixel_count", 32'(pixel_count),   32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 8 back-to-back pixels, ack tied high
    mif.mem_ack = 1'b1;
    for (int i = 0; i < 8; i++)
      send_px(8'(i), 8'h10, 24'hA00000 + 24'(i), 16'h1000 + 16'(i), 1'b1);
    wait_drain(40, "t1");
    repeat (3) tick();
    chk("t1_overflow",    32'(overflow),    32'h0);
    chk("t1_pixel_count", 32'(pixel_count), 32'd8);
    chk("t1_busy",        32'(busy),        32'h0);
    chk("t1_no_frame",    32'(fd_pulses),   32'd0);

    // 12 pixels into an 8-deep FIFO while memory stalls for 20 cycles
    mif.mem_ack = 1'b0;
    for (int i = 0; i < 12; i++)
      send_px(8'h30 + 8'(i), 8'h40, 24'h001000 + 24'(i), 16'h4030 + 16'(i), i < 8);
    repeat (8) tick();
    chk("t2_overflow",  32'(overflow),      32'h1);
    chk("t2_busy",      32'(busy),          32'h1);
    chk("t2_req_held",  32'(mif.mem_req),   32'h1);
    chk("t2_head_addr", 32'(mif.mem_addr),  32'h4030);
    chk("t2_head_data", 32'(mif.mem_wdata), 32'h001000);
    mif.mem_ack = 1'b1;
    wait_drain(40, "t2");
    repeat (3) tick();
    chk("t2_pixel_count", 32'(pixel_count), 32'd16);
    chk("t2_sticky_ovf",  32'(overflow),    32'h1);

    // done held high 2 cycles while 3 pixels wait
    mif.mem_ack = 1'b0;
    for (int i = 0; i < 3; i++)
      send_px(8'h50 + 8'(i), 8'h60, 24'h00AB00 + 24'(i), 16'h6050 + 16'(i), 1'b1);
    done = 1'b1;
    repeat (2) tick();
    done = 1'b0;
    repeat (2) tick();
    chk("t3_no_early_frame", 32'(fd_pulses), 32'd0);
    mif.mem_ack = 1'b1;
    wait_drain(40, "t3");
    repeat (10) tick();
    chk("t3_frame_pulses", 32'(fd_pulses),    32'd1);
    chk("t3_frame_after",  32'(fd_at_writes), 32'd19);

    // full clear with a pixel injected mid-way
    clear_req   = 1'b1;
    clear_color = 24'h000000;
    for (int i = 0; i < 65536; i++)
      exp_q.push_back('{addr: 16'(i), data: 24'h000000, bulk: 1'b1});
    tick();
    clear_req   = 1'b0;
    clear_color = 24'hFFFFFF;
    repeat (5) tick();
    chk("t4_count_cleared", 32'(pixel_count), 32'd0);
    chk("t4_ovf_cleared",   32'(overflow),    32'h0);
    chk("t4_busy",          32'(busy),        32'h1);
    send_px(8'd10, 8'd20, 24'h123456, 16'h140A, 1'b1);
    repeat (100) tick();
    chk("t4_count_mid", 32'(pixel_count), 32'd0);
    wait_drain(70000, "t4");
    repeat (3) tick();
    chk("t4_clear_writes", 32'(bulk_n),      32'd65536);
    chk("t4_clear_bad",    32'(bulk_bad),    32'd0);
    chk("t4_pixel_count",  32'(pixel_count), 32'd1);
    chk("t4_idle",         32'(busy),        32'h0);

    // latency from idle, then reset mid-WRITE with ack low
    mif.mem_ack = 1'b0;
    send_px(8'h77, 8'h66, 24'h0F0F0F, 16'h6677, 1'b0);
    tick();
    chk("t5_latency_req",  32'(mif.mem_req),  32'h1);
    chk("t5_latency_addr", 32'(mif.mem_addr), 32'h6677);
    rst_n = 1'b0;
    #2;
    chk("t5_rst_req",   32'(mif.mem_req),   32'h0);
    chk("t5_rst_busy",  32'(busy),          32'h0);
    chk("t5_rst_count", 32'(pixel_count),   32'd0);
    chk("t5_rst_ovf",   32'(overflow),      32'h0);
    chk("t5_rst_addr",  32'(mif.mem_addr),  32'h0);
    tick();
    rst_n       = 1'b1;
    mif.mem_ack = 1'b1;
    w0          = writes;
    repeat (20) tick();
    chk("t5_no_writes", 32'(writes), 32'(w0));
    chk("t5_idle",      32'(busy),   32'h0);
    chk("final_queue",  32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, sets pixel FIFO entries; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all logic is rising-edge triggered.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pixel_valid  input  1  pixel strobe from the drawer; one pixel per high cycle; no backpressure.
REQ-005 px, py  input  8 each  pixel coordinates.
REQ-006 pixel_color  input  24  pixel RGB.
REQ-007 done  input  1  drawer completion level; may stay high for several cycles.
REQ-008 clear_req  input  1  request to fill the whole framebuffer with clear_color.
REQ-009 clear_color  input  24  fill colour, sampled when clear is accepted.
REQ-010 mem_req, mem_we  output  1 each  write request; mem_we equals mem_req.
REQ-011 mem_addr  output  16  write address {py,px}.
REQ-012 mem_wdata  output  24  write data.
REQ-013 mem_ack  input  1  memory accepts the current request in the cycle it is high.
REQ-014 busy  output  1  high in any state other than IDLE, or while the FIFO is non-empty.
REQ-015 overflow  output  1  sticky flag: a pixel was dropped.
REQ-016 frame_done  output  1  one-cycle pulse when a drawn frame is fully written.
REQ-017 pixel_count  output  16  pixels written since the last clear; saturates at 16'hFFFF.

Function
REQ-018 The block SHALL push {py,px,pixel_color} into the FIFO in every cycle with pixel_valid high, in every state.
REQ-019 A push SHALL be accepted when the FIFO is full only if a pop occurs in the same cycle; otherwise the pixel SHALL be dropped and overflow set.
REQ-020 The FSM SHALL have the states IDLE, WRITE, CLEAR and FLUSH.
REQ-021 IDLE->CLEAR SHALL occur when clear_req is high and the FIFO is empty; clear_color is latched, the clear address is set to 0, and overflow and pixel_count are cleared.
REQ-022 IDLE->WRITE SHALL occur when the FIFO is non-empty; the CLEAR transition takes priority in the same cycle.
REQ-023 A rising edge of done SHALL set an internal frame_pend flag in any state; the level of done is ignored.
REQ-024 In WRITE, mem_req SHALL be asserted with mem_addr and mem_wdata taken from the FIFO head.
REQ-025 The FIFO head SHALL be popped on mem_ack; if the FIFO is still non-empty, the next entry SHALL be presented with mem_req high in the following cycle.
REQ-026 mem_req, mem_addr and mem_wdata SHALL remain stable while mem_req is high and mem_ack is low.
REQ-027 A pixel pushed into an empty FIFO while the block is idle SHALL appear on mem_req no later than 2 cycles after its pixel_valid cycle.
REQ-028 WRITE SHALL go to FLUSH when the FIFO drains and frame_pend is set, and to IDLE when the FIFO drains and frame_pend is clear.
REQ-029 FLUSH SHALL pulse frame_done for one cycle, clear frame_pend, and return to IDLE.
REQ-030 From IDLE, frame_pend set with the FIFO empty SHALL go to FLUSH.
REQ-031 In CLEAR, the block SHALL write clear_color to addresses 0..65535 in order, advancing the address on each mem_ack.
REQ-032 After the mem_ack for address 65535, CLEAR SHALL go to IDLE; the address counter wraps to 0 without a carry-out.
REQ-033 Pixels arriving during CLEAR SHALL be queued in the FIFO and written after the clear completes.
REQ-034 Writes in CLEAR SHALL NOT increment pixel_count.
REQ-035 pixel_count SHALL increment on each mem_ack in WRITE.
REQ-036 clear_req received outside IDLE, or with the FIFO non-empty, SHALL be held off until both conditions hold; the block does not latch it.

Reset
REQ-037 While rst_n is low, the following SHALL be 0 immediately, independent of clk: mem_req, mem_we, mem_addr, mem_wdata, busy, overflow, frame_done, pixel_count.
REQ-038 While rst_n is low, the FIFO SHALL be emptied, frame_pend cleared, the done edge detector cleared, and the FSM set to IDLE.
REQ-039 Reset asserted mid-WRITE or mid-CLEAR SHALL abandon the outstanding request with no further mem_req.

Structure
REQ-040 Shared package fb_pkg SHALL hold the FSM state encoding, ADDR_W=16, COLOR_W=24, and the packed pixel entry type {py,px,color}.
REQ-041 The FIFO SHALL be a sub-module named pixel_fifo, parameterised by depth and width, with push, pop, full, empty and a registered head output.

Verification
REQ-042 The bench SHALL send 8 back-to-back pixels with mem_ack tied high -> 8 writes in order, no overflow, pixel_count=8.
REQ-043 The bench SHALL send 12 back-to-back pixels with FIFO_DEPTH=8 and mem_ack low for 20 cycles -> overflow=1, the first 8 or 9 pixels written in order, the remainder dropped.
REQ-044 The bench SHALL hold done high for 2 cycles while 3 pixels are queued -> exactly one frame_done pulse, after the 3rd mem_ack.
REQ-045 The bench SHALL issue clear_req with clear_color=24'h000000 and mem_ack high -> 65536 writes at 0x0000..0xFFFF, pixel_count=0, then IDLE.
REQ-046 The bench SHALL inject a pixel (px=10, py=20) mid-clear -> it is written with addr=16'h140A after address 0xFFFF.
REQ-047 The bench SHALL pull rst_n low during WRITE with mem_ack low -> mem_req=0 at once, busy=0, and no writes after release.
